// File: rtl/fetch_unit_pkg.sv
// Shared constants and the fetch FSM state encoding for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_IDLE       = 3'd1,
    ST_REQ        = 3'd2,
    ST_WAIT       = 3'd3,
    ST_FLUSH_REQ  = 3'd4,
    ST_FLUSH_WAIT = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO holding {pc, instr} pairs; flush wins over push, push at full is
// accepted only together with a pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/gnt/rvalid fetch bus with one
// outstanding transaction, and feeds IF/ID from a prefetch FIFO.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned                  INSTR_ADDR_WIDTH = 32,
  parameter logic [INSTR_ADDR_WIDTH-1:0]  BOOT_ADDR        = '0,
  parameter int unsigned                  FIFO_DEPTH       = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_stall_i,
  input  logic                        branch_taken_i,
  input  logic [INSTR_ADDR_WIDTH-1:0] branch_target_i,
  output logic                        instr_req_o,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                        instr_gnt_i,
  input  logic                        instr_rvalid_i,
  input  logic [INSTR_ADDR_WIDTH-1:0] instr_rdata_i,
  output logic                        instr_valid_o,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_o,
  output logic [INSTR_ADDR_WIDTH-1:0] pc_o,
  output logic [2:0]                  dbg_state_o
);

  localparam int unsigned W  = INSTR_ADDR_WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e   state_q, state_d;
  logic [W-1:0]   fetch_addr_q, fetch_addr_d;
  logic [W-1:0]   pend_addr_q, pend_addr_d;
  logic [W-1:0]   target;
  logic           push, pop, space, empty, full;
  logic [CW-1:0]  count;
  logic [2*W-1:0] head;
  logic           unused_tgt_lsbs;

  assign target          = {branch_target_i[W-1:2], 2'b00};
  assign unused_tgt_lsbs = ^branch_target_i[1:0];

  assign pop   = !empty && !fetch_stall_i && !branch_taken_i;
  assign push  = (state_q == ST_WAIT) && instr_rvalid_i && !branch_taken_i;
  assign space = full ? (pop && !push)
                      : ((int'(count) + int'(push) - int'(pop)) < int'(FIFO_DEPTH));

  // Valid/ready: a request is accepted on a cycle with req && gnt; req and addr hold
  // until then. rvalid returns one response per grant, never in the grant cycle.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pend_addr_d  = pend_addr_q;
    instr_req_o  = 1'b0;
    instr_addr_o = fetch_addr_q;
    case (state_q)
      ST_RESET: state_d = ST_REQ;
      ST_IDLE: begin
        if (branch_taken_i) begin
          fetch_addr_d = target;
          state_d      = ST_REQ;
        end else if (space) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        instr_req_o = 1'b1;
        if (branch_taken_i) begin
          fetch_addr_d = target;
          pend_addr_d  = fetch_addr_q;
          state_d      = instr_gnt_i ? ST_FLUSH_WAIT : ST_FLUSH_REQ;
        end else if (instr_gnt_i) begin
          fetch_addr_d = fetch_addr_q + W'(4);
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (instr_rvalid_i) begin
          if (branch_taken_i) begin
            fetch_addr_d = target;
            state_d      = ST_REQ;
          end else if (space) begin
            instr_req_o = 1'b1;
            if (instr_gnt_i) begin
              fetch_addr_d = fetch_addr_q + W'(4);
              state_d      = ST_WAIT;
            end else begin
              state_d = ST_REQ;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else if (branch_taken_i) begin
          fetch_addr_d = target;
          state_d      = ST_FLUSH_WAIT;
        end
      end
      ST_FLUSH_REQ: begin
        // The raised request keeps its pre-branch address until granted.
        instr_req_o  = 1'b1;
        instr_addr_o = pend_addr_q;
        if (branch_taken_i) fetch_addr_d = target;
        if (instr_gnt_i) state_d = ST_FLUSH_WAIT;
      end
      ST_FLUSH_WAIT: begin
        if (branch_taken_i) fetch_addr_d = target;
        if (instr_rvalid_i) state_d = ST_REQ;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      fetch_addr_q <= BOOT_ADDR;
      pend_addr_q  <= BOOT_ADDR;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  // Pushed PC is the address just before fetch_addr, which advanced on the grant.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (branch_taken_i),
    .data_i  ({fetch_addr_q - W'(4), instr_rdata_i}),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );

  assign instr_valid_o = !empty;
  assign instr_o       = empty ? W'(NOP_INSTR) : head[W-1:0];
  assign pc_o          = empty ? '0 : head[2*W-1:W];
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for the zero-wait flow plus hand-written
// sequences for back-pressure, grant delay, branch flushes, PC wrap and reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [2:0]  dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model controls and state
  int          gnt_delay = 0;
  int          rv_delay  = 1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_left = 0;
  int          req_cycles = 0;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] exp_q[$];

  fetch_unit #(
    .INSTR_ADDR_WIDTH (32),
    .BOOT_ADDR        (32'h0),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_stall_i   (fetch_stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .instr_req_o     (instr_req_o),
    .instr_addr_o    (instr_addr_o),
    .instr_gnt_i     (instr_gnt_i),
    .instr_rvalid_i  (instr_rvalid_i),
    .instr_rdata_i   (instr_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .dbg_state_o     (dbg_state_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory: rvalid at negedge, grant decided 1 unit later from the settled request
  initial begin
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    forever begin
      @(negedge clk);
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'hDEAD_BEEF;
      if (!rst_n) begin
        pend       = 1'b0;
        req_cycles = 0;
      end else if (pend) begin
        pend_left--;
        if (pend_left <= 0) begin
          instr_rvalid_i = 1'b1;
          instr_rdata_i  = ~pend_addr;
          pend           = 1'b0;
        end
      end
      #1;
      if (rst_n && instr_req_o && !pend) begin
        if (req_cycles >= gnt_delay) begin
          instr_gnt_i = 1'b1;
          pend        = 1'b1;
          pend_addr   = instr_addr_o;
          pend_left   = rv_delay;
          req_cycles  = 0;
        end else begin
          req_cycles++;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    fetch_stall_i   = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = '0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n;
    n = 0;
    settle();
    while (!instr_valid_o && n < max_cycles) begin
      tick();
      settle();
      n++;
    end
    chk(name, {31'b0, instr_valid_o}, 32'h1);
  endtask

  function automatic void add_vec(input logic st, input logic br, input logic [31:0] tgt,
                                  input logic req, input logic [31:0] addr,
                                  input logic vld, input logic [31:0] pc);
    vec_t v;
    v.stall = st; v.br = br; v.tgt = tgt;
    v.exp_req = req; v.exp_addr = addr; v.exp_valid = vld; v.exp_pc = pc;
    vq.push_back(v);
  endfunction

  initial begin
    logic [31:0] exp_instr;
    int          run_len;
    int          pops;
    logic        in_run;
    logic        found;

    // cycle table, zero-wait memory; row i is cycle i after reset release
    //       stall br    tgt           req   addr          valid pc
    add_vec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
    add_vec(1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0);
    add_vec(1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 32'h0);
    add_vec(1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0);
    add_vec(1'b0, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h4);
    add_vec(1'b1, 1'b0, 32'h0,        1'b0, 32'h10,       1'b1, 32'h8);
    add_vec(1'b1, 1'b0, 32'h0,        1'b0, 32'h10,       1'b1, 32'h8);
    add_vec(1'b0, 1'b0, 32'h0,        1'b0, 32'h10,       1'b1, 32'h8);
    add_vec(1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'hC);
    add_vec(1'b0, 1'b0, 32'h0,        1'b1, 32'h14,       1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 32'h100,      1'b0, 32'h18,       1'b1, 32'h10);
    add_vec(1'b0, 1'b0, 32'h0,        1'b1, 32'h100,      1'b0, 32'h0);
    add_vec(1'b0, 1'b0, 32'h0,        1'b1, 32'h104,      1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 32'h202,      1'b0, 32'h108,      1'b1, 32'h100);
    add_vec(1'b0, 1'b0, 32'h0,        1'b1, 32'h200,      1'b0, 32'h0);
    add_vec(1'b0, 1'b0, 32'h0,        1'b1, 32'h204,      1'b0, 32'h0);
    add_vec(1'b0, 1'b0, 32'h0,        1'b1, 32'h208,      1'b1, 32'h200);

    gnt_delay = 0; rv_delay = 1;
    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      fetch_stall_i   = vq[i].stall;
      branch_taken_i  = vq[i].br;
      branch_target_i = vq[i].tgt;
      settle();
      exp_instr = vq[i].exp_valid ? ~vq[i].exp_pc : NOP_INSTR;
      chk($sformatf("tbl%0d_req", i), {31'b0, instr_req_o}, {31'b0, vq[i].exp_req});
      if (vq[i].exp_req || i == 0)
        chk($sformatf("tbl%0d_addr", i), instr_addr_o, vq[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid_o}, {31'b0, vq[i].exp_valid});
      chk($sformatf("tbl%0d_pc", i), pc_o, vq[i].exp_pc);
      chk($sformatf("tbl%0d_instr", i), instr_o, exp_instr);
      tick();
    end
    fetch_stall_i = 1'b0; branch_taken_i = 1'b0;

    // back-pressure: stall 10 cycles, then drain against an in-order scoreboard
    do_reset();
    fetch_stall_i = 1'b1;
    repeat (10) tick();
    settle();
    chk("bp_req_drop", {31'b0, instr_req_o}, 32'h0);
    chk("bp_head_valid", {31'b0, instr_valid_o}, 32'h1);
    chk("bp_head_pc", pc_o, 32'h0);
    tick();
    fetch_stall_i = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(32'(k * 4));
    run_len = 0; pops = 0; in_run = 1'b1;
    for (int c = 0; c < 12; c++) begin
      settle();
      if (instr_valid_o) begin
        if (in_run) run_len++;
        pops++;
        if (exp_q.size() > 0) begin
          chk("bp_pc", pc_o, exp_q[0]);
          chk("bp_instr", instr_o, ~exp_q[0]);
          void'(exp_q.pop_front());
        end
      end else begin
        in_run = 1'b0;
      end
      tick();
    end
    chk("bp_buffered", 32'(run_len), 32'(DEPTH));
    chk("bp_pop_count", 32'(pops), 32'd11);

    // grant delayed 3 cycles: address held, data tagged with the right PC
    gnt_delay = 3; rv_delay = 1;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      tick();
      settle();
      chk($sformatf("gd_req_c%0d", c), {31'b0, instr_req_o}, 32'h1);
      chk($sformatf("gd_addr_c%0d", c), instr_addr_o, 32'h0);
    end
    tick();
    wait_valid("gd_first_valid", 10);
    chk("gd_pc0", pc_o, 32'h0);
    chk("gd_instr0", instr_o, ~32'h0);
    tick();
    wait_valid("gd_second_valid", 20);
    chk("gd_pc1", pc_o, 32'h4);

    // branch while WAIT without rvalid: late response discarded
    gnt_delay = 0; rv_delay = 3;
    do_reset();
    tick();
    tick();
    branch_taken_i = 1'b1; branch_target_i = 32'h100;
    settle();
    chk("bw_valid_low", {31'b0, instr_valid_o}, 32'h0);
    tick();
    branch_taken_i = 1'b0;
    settle();
    chk("bw_flush_wait_req", {31'b0, instr_req_o}, 32'h0);
    tick();
    wait_valid("bw_valid", 30);
    chk("bw_pc", pc_o, 32'h100);
    chk("bw_instr", instr_o, ~32'h100);

    // branch in the same cycle as rvalid
    gnt_delay = 0; rv_delay = 1;
    do_reset();
    tick();
    tick();
    branch_taken_i = 1'b1; branch_target_i = 32'h100;
    settle();
    chk("brv_req_low", {31'b0, instr_req_o}, 32'h0);
    tick();
    branch_taken_i = 1'b0;
    wait_valid("brv_valid", 20);
    chk("brv_pc", pc_o, 32'h100);

    // branch during REQ without gnt: old address granted first, then target
    gnt_delay = 3; rv_delay = 1;
    do_reset();
    tick();
    branch_taken_i = 1'b1; branch_target_i = 32'h100;
    settle();
    chk("br_req_addr_c1", instr_addr_o, 32'h0);
    tick();
    branch_taken_i = 1'b0;
    settle();
    chk("br_flush_req", {31'b0, instr_req_o}, 32'h1);
    chk("br_flush_addr", instr_addr_o, 32'h0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      settle();
      if (instr_req_o && instr_addr_o == 32'h100) found = 1'b1;
    end
    chk("br_target_req", {31'b0, found}, 32'h1);
    tick();
    wait_valid("br_valid", 30);
    chk("br_pc", pc_o, 32'h100);

    // second branch during the flush wins
    do_reset();
    tick();
    branch_taken_i = 1'b1; branch_target_i = 32'h100;
    tick();
    branch_target_i = 32'h200;
    tick();
    branch_taken_i = 1'b0;
    wait_valid("br2_valid", 40);
    chk("br2_pc", pc_o, 32'h200);

    // PC wrap
    gnt_delay = 0; rv_delay = 1;
    do_reset();
    tick();
    branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    tick();
    branch_taken_i = 1'b0;
    wait_valid("wrap_first_valid", 20);
    chk("wrap_pc_top", pc_o, 32'hFFFF_FFFC);
    tick();
    settle();
    chk("wrap_valid", {31'b0, instr_valid_o}, 32'h1);
    chk("wrap_pc_zero", pc_o, 32'h0);

    // reset in the middle of WAIT
    rv_delay = 4;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      settle();
      if (dbg_state_o == ST_WAIT && !instr_rvalid_i) found = 1'b1;
    end
    chk("rst_found_wait", {31'b0, found}, 32'h1);
    tick();
    rst_n = 1'b0;
    tick();
    settle();
    chk("rst_req", {31'b0, instr_req_o}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("rst_addr", instr_addr_o, 32'h0);
    chk("rst_instr", instr_o, NOP_INSTR);
    tick();
    rv_delay = 1;
    rst_n = 1'b1;
    wait_valid("rst_restart_valid", 10);
    chk("rst_restart_pc", pc_o, 32'h0);

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
